sram_responder: RTL and testbench

Memory-side responder for the CPU's SRAM-style bus (`en`, `we[3:0]`, `addr`, `wdata`, `rdata`), used as the data-SRAM endpoint in the SoC top.
- Returns read data one cycle after a read request.
- Applies byte-lane writes.
- Decodes a small memory-mapped register window: scratch register, LED register, free-running timer and read-only ID.
- Sits directly behind the `data_sram_*` port group of `mycpu_top`.

---
 rtl/sram_responder.sv | 139 +++++++++++++
 tb/tb_sram_responder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// sram_responder: data-SRAM endpoint for the CPU's SRAM-style bus.
//   Reads return data one cycle after the request. Writes apply byte-lane
//   enables at the edge. A small MMIO window (scratch, LED, timer, ID) is
//   decoded when sram_addr[31:16] == MMIO_HI.
// Ports:
//   clk, resetn      - clock, asynchronous active-low reset
//   sram_en          - access request this cycle
//   sram_we[3:0]     - byte write enables (0 with en = read)
//   sram_addr[31:0]  - byte address ([1:0] ignored)
//   sram_wdata[31:0] - write data
//   sram_rdata[31:0] - registered read data
//   led[15:0]        - low half of the LED register
// Build option: define SRAM_RESP_TIMER_EN to include the free-running timer
//   at MMIO offset 0x2; otherwise that offset reads 0 and ignores writes.
module sram_responder #(
  parameter int          ADDR_W   = 14,
  parameter logic [15:0] MMIO_HI  = 16'hbfaf,
  parameter logic [31:0] ID_VALUE = 32'h4c41_4238
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic [15:0] led
);

  localparam logic [13:0] OFF_SCRATCH = 14'h0;
  localparam logic [13:0] OFF_LED     = 14'h1;
  localparam logic [13:0] OFF_TIMER   = 14'h2;
  localparam logic [13:0] OFF_ID      = 14'h3;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  // Decode
  logic              is_mmio, is_rd, is_wr, mmio_wr, ram_wr;
  logic [13:0]       mmio_off;
  logic [ADDR_W-1:0] ram_idx;
  logic              unused_addr;

  assign is_mmio  = (sram_addr[31:16] == MMIO_HI);
  assign mmio_off = sram_addr[15:2];
  // Upper RAM address bits alias; they are deliberately not checked.
  assign ram_idx  = sram_addr[ADDR_W+1:2];
  assign is_rd    = sram_en && (sram_we == 4'h0);
  assign is_wr    = sram_en && (sram_we != 4'h0);
  assign mmio_wr  = is_wr && is_mmio;
  assign ram_wr   = is_wr && !is_mmio;
  assign unused_addr = ^sram_addr[1:0];

  // RAM array: not reset, written only when resetn is high.
  logic [31:0] mem [2**ADDR_W];
  logic [31:0] ram_rdata;
  assign ram_rdata = mem[ram_idx];

  always_ff @(posedge clk or negedge resetn) begin
    if (resetn && ram_wr) begin
      for (int i = 0; i < 4; i++)
        if (sram_we[i]) mem[ram_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
    end
  end

  // MMIO registers
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] led_q, led_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] timer_rd;

  always_comb begin
    scratch_d = scratch_q;
    led_d     = led_q;
    if (mmio_wr && mmio_off == OFF_SCRATCH) scratch_d = lane_merge(scratch_q, sram_wdata, sram_we);
    if (mmio_wr && mmio_off == OFF_LED)     led_d     = lane_merge(led_q, sram_wdata, sram_we);
  end

`ifdef SRAM_RESP_TIMER_EN
  logic [31:0] timer_q, timer_d;

  // A write replaces the written lanes and takes the place of that
  // cycle's increment; counting resumes on the following edge.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (mmio_wr && mmio_off == OFF_TIMER) timer_d = lane_merge(timer_q, sram_wdata, sram_we);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) timer_q <= '0;
    else         timer_q <= timer_d;
  end

  assign timer_rd = timer_q;
`else
  assign timer_rd = '0;
`endif

  // Read mux: values seen are those held before the edge.
  logic [31:0] mmio_rdata;
  always_comb begin
    mmio_rdata = '0;
    case (mmio_off)
      OFF_SCRATCH: mmio_rdata = scratch_q;
      OFF_LED:     mmio_rdata = led_q;
      OFF_TIMER:   mmio_rdata = timer_rd;
      OFF_ID:      mmio_rdata = ID_VALUE;
      default:     mmio_rdata = '0;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (is_rd) rdata_d = is_mmio ? mmio_rdata : ram_rdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scratch_q <= '0;
      led_q     <= '0;
      rdata_q   <= '0;
    end else begin
      scratch_q <= scratch_d;
      led_q     <= led_d;
      rdata_q   <= rdata_d;
    end
  end

  assign sram_rdata = rdata_q;
  assign led        = led_q[15:0];

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: read expectations are queued when
// a read is driven and popped when the registered data appears.
module tb_sram_responder;

  localparam logic [31:0] ID_V = 32'h4c41_4238;
  localparam logic [31:0] A_SCR = 32'hbfaf_0000;
  localparam logic [31:0] A_LED = 32'hbfaf_0004;
  localparam logic [31:0] A_TMR = 32'hbfaf_0008;
  localparam logic [31:0] A_ID  = 32'hbfaf_000c;
`ifdef SRAM_RESP_TIMER_EN
  localparam bit TMR_ON = 1'b1;
`else
  localparam bit TMR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sram_en = 1'b0;
  logic [3:0]  sram_we = 4'h0;
  logic [31:0] sram_addr = '0;
  logic [31:0] sram_wdata = '0;
  logic [31:0] sram_rdata;
  logic [15:0] led;

  int          n_run = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic        rd_vld = 1'b0;

  always #5 clk = ~clk;

  sram_responder dut (
    .clk        (clk),
    .resetn     (resetn),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .led        (led)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Track which edges carried a read; compare half a cycle later.
  always @(posedge clk or negedge resetn)
    if (!resetn) rd_vld <= 1'b0;
    else         rd_vld <= sram_en && (sram_we == 4'h0);

  always @(negedge clk)
    if (rd_vld) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else                   chk("rd", sram_rdata, exp_q.pop_front());
    end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    sram_en = 1'b1; sram_we = we; sram_addr = a; sram_wdata = d;
    @(negedge clk);
    sram_en = 1'b0; sram_we = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    sram_en = 1'b1; sram_we = 4'h0; sram_addr = a;
    exp_q.push_back(exp);
    @(negedge clk);
    sram_en = 1'b0;
  endtask

  task automatic idle(input int n);
    sram_en = 1'b0; sram_we = 4'h0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] bb_addr [4];
    logic [31:0] bb_data [4];
    bb_addr = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108, 32'h0000_fffc};
    bb_data = '{32'h0102_0304, 32'h5a5a_0f0f, 32'h8000_0001, 32'hfeed_face};

    repeat (2) @(negedge clk);
    chk("rst_rdata", sram_rdata, 32'h0);
    chk("rst_led", {16'h0, led}, 32'h0);
    resetn = 1'b1;

    // Access on the first edge after release is serviced; timer 0 then 1.
    rd(A_TMR, 32'h0);
    rd(A_TMR, TMR_ON ? 32'h1 : 32'h0);

    wr(32'h0000_0010, 32'hdead_beef, 4'hf);
    rd(32'h0000_0010, 32'hdead_beef);

    wr(32'h0000_0020, 32'haabb_ccdd, 4'hf);
    wr(32'h0000_0020, 32'h1122_3344, 4'b0101);
    rd(32'h0000_0020, 32'haa22_cc44);

    // Upper RAM address bits alias onto the same word.
    rd(32'h0001_0010, 32'hdead_beef);

    wr(A_LED, 32'h0000_a5a5, 4'hf);
    chk("led_out", {16'h0, led}, 32'h0000_a5a5);
    rd(A_LED, 32'h0000_a5a5);
    wr(A_LED, 32'h1234_5678, 4'b1100);
    chk("led_hi_lanes", {16'h0, led}, 32'h0000_a5a5);
    rd(A_LED, 32'h1234_a5a5);

    wr(A_SCR, 32'hcafe_f00d, 4'hf);
    rd(A_SCR, 32'hcafe_f00d);

    wr(A_ID, 32'h0, 4'hf);
    rd(A_ID, ID_V);
    wr(32'hbfaf_0040, 32'hffff_ffff, 4'hf);
    rd(32'hbfaf_0040, 32'h0);

    wr(A_TMR, 32'hffff_fffe, 4'hf);
    idle(1);
    rd(A_TMR, TMR_ON ? 32'hffff_ffff : 32'h0);
    rd(A_TMR, 32'h0);

    for (int i = 0; i < 4; i++) wr(bb_addr[i], bb_data[i], 4'hf);
    for (int i = 0; i < 4; i++) rd(bb_addr[i], bb_data[i]);

    rd(bb_addr[1], bb_data[1]);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("hold", sram_rdata, bb_data[1]);
    end

    // Asynchronous reset in the middle of the high phase.
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_rdata", sram_rdata, 32'h0);
    chk("async_led", {16'h0, led}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    rd(A_TMR, 32'h0);
    rd(A_TMR, TMR_ON ? 32'h1 : 32'h0);
    rd(A_LED, 32'h0);
    rd(A_SCR, 32'h0);

    idle(2);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
